// File: rtl/lieat_exu_oitf_if.sv
// Dispatch/retire/query bundle between the EXU front end and the outstanding-instruction tracker.
// Latency: wires only, no storage.
// Backpressure: dis_ready deasserts while the tracker is full; retire requests while empty are dropped.
interface lieat_exu_oitf_if #(
    parameter int OITF_DEPTH = 4,
    parameter int PTR_W      = 2,
    parameter int REG_IDX    = 5,
    parameter int XLEN       = 32
);
    // allocate side
    logic               dis_ena;
    logic               dis_ready;
    logic               dis_rdwen;
    logic [REG_IDX-1:0] dis_rdidx;
    logic [XLEN-1:0]    dis_pc;
    logic [PTR_W-1:0]   dis_ptr;
    // retire side
    logic               ret_ena;
    logic [PTR_W-1:0]   ret_ptr;
    logic               ret_rdwen;
    logic [REG_IDX-1:0] ret_rdidx;
    logic [XLEN-1:0]    ret_pc;
    // hazard query from the instruction currently in dispatch
    logic               disp_rs1en;
    logic               disp_rs2en;
    logic               disp_rdwen;
    logic [REG_IDX-1:0] disp_rs1idx;
    logic [REG_IDX-1:0] disp_rs2idx;
    logic [REG_IDX-1:0] disp_rdidx;
    logic               oitfrd_match_disprs1;
    logic               oitfrd_match_disprs2;
    logic               oitfrd_match_disprd;
    logic               oitf_waw_dep;
    // status
    logic               oitf_empty;
    logic               oitf_full;

    modport master (
        output dis_ena, dis_rdwen, dis_rdidx, dis_pc, ret_ena,
               disp_rs1en, disp_rs2en, disp_rdwen, disp_rs1idx, disp_rs2idx, disp_rdidx,
        input  dis_ready, dis_ptr, ret_ptr, ret_rdwen, ret_rdidx, ret_pc,
               oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd,
               oitf_waw_dep, oitf_empty, oitf_full
    );

    modport slave (
        input  dis_ena, dis_rdwen, dis_rdidx, dis_pc, ret_ena,
               disp_rs1en, disp_rs2en, disp_rdwen, disp_rs1idx, disp_rs2idx, disp_rdidx,
        output dis_ready, dis_ptr, ret_ptr, ret_rdwen, ret_rdidx, ret_pc,
               oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd,
               oitf_waw_dep, oitf_empty, oitf_full
    );
endinterface

// File: rtl/lieat_exu_oitf.sv
// Tracks long-latency (LSU/MULDIV) instructions from dispatch until in-order write-back retire.
// Latency: allocate/retire visible one cycle after the firing edge; hazard flags combinational from state.
// Backpressure: dis_ready = ~full (no same-cycle retire bypass); retire while empty is ignored.
module lieat_exu_oitf #(
    parameter int OITF_DEPTH = 4,
    parameter int PTR_W      = 2,
    parameter int REG_IDX    = 5,
    parameter int XLEN       = 32
) (
    input  logic              clock,
    input  logic              reset,
    lieat_exu_oitf_if.slave   bus
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OITF_DEPTH - 1);

    logic [OITF_DEPTH-1:0] vld_q;
    logic [OITF_DEPTH-1:0] rdwen_q;
    logic [REG_IDX-1:0]    rdidx_q [OITF_DEPTH];
    logic [XLEN-1:0]       pc_q    [OITF_DEPTH];

    logic [PTR_W-1:0] alc_ptr_q;
    logic [PTR_W-1:0] ret_ptr_q;
    logic             alc_flg_q;
    logic             ret_flg_q;

    logic oitf_empty;
    logic oitf_full;
    logic alc_fire;
    logic ret_fire;

    logic hit_rs1;
    logic hit_rs2;
    logic hit_rd;
    logic hit_oldest_rd;

    // Equal pointers mean empty or full; the wrap flags tell which.
    assign oitf_empty = (alc_ptr_q == ret_ptr_q) && (alc_flg_q == ret_flg_q);
    assign oitf_full  = (alc_ptr_q == ret_ptr_q) && (alc_flg_q != ret_flg_q);

    assign alc_fire = bus.dis_ena & ~oitf_full;
    assign ret_fire = bus.ret_ena & ~oitf_empty;

    // Allocate and retire pointers, each with a wrap flag that flips on rollover.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alc_ptr_q <= '0;
            alc_flg_q <= 1'b0;
            ret_ptr_q <= '0;
            ret_flg_q <= 1'b0;
        end else begin
            if (alc_fire) begin
                if (alc_ptr_q == PTR_LAST) alc_flg_q <= ~alc_flg_q;
                alc_ptr_q <= alc_ptr_q + PTR_W'(1);
            end
            if (ret_fire) begin
                if (ret_ptr_q == PTR_LAST) ret_flg_q <= ~ret_flg_q;
                ret_ptr_q <= ret_ptr_q + PTR_W'(1);
            end
        end
    end

    // Entry storage: retire clears the oldest valid bit, allocate fills the slot at alc_ptr.
    // Both can only hit the same slot when full or empty, where just one of them fires.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q   <= '0;
            rdwen_q <= '0;
            for (int i = 0; i < OITF_DEPTH; i++) begin
                rdidx_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            if (ret_fire) begin
                vld_q[ret_ptr_q] <= 1'b0;
            end
            if (alc_fire) begin
                vld_q[alc_ptr_q]   <= 1'b1;
                rdwen_q[alc_ptr_q] <= bus.dis_rdwen;
                rdidx_q[alc_ptr_q] <= bus.dis_rdidx;
                pc_q[alc_ptr_q]    <= bus.dis_pc;
            end
        end
    end

    // Compare every live rd-writing entry against the dispatch operands; x0 never creates a hazard.
    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        hit_rd  = 1'b0;
        for (int i = 0; i < OITF_DEPTH; i++) begin
            if (vld_q[i] && rdwen_q[i]) begin
                if ((rdidx_q[i] == bus.disp_rs1idx) && (bus.disp_rs1idx != '0)) hit_rs1 = 1'b1;
                if ((rdidx_q[i] == bus.disp_rs2idx) && (bus.disp_rs2idx != '0)) hit_rs2 = 1'b1;
                if ((rdidx_q[i] == bus.disp_rdidx)  && (bus.disp_rdidx  != '0)) hit_rd  = 1'b1;
            end
        end
    end

    assign hit_oldest_rd = vld_q[ret_ptr_q] && rdwen_q[ret_ptr_q] &&
                           (rdidx_q[ret_ptr_q] == bus.disp_rdidx) && (bus.disp_rdidx != '0);

    assign bus.oitfrd_match_disprs1 = bus.disp_rs1en & hit_rs1;
    assign bus.oitfrd_match_disprs2 = bus.disp_rs2en & hit_rs2;
    assign bus.oitfrd_match_disprd  = bus.disp_rdwen & hit_rd;
    assign bus.oitf_waw_dep         = bus.disp_rdwen & ~oitf_empty & hit_oldest_rd;

    assign bus.dis_ready  = ~oitf_full;
    assign bus.dis_ptr    = alc_ptr_q;
    assign bus.ret_ptr    = ret_ptr_q;
    assign bus.ret_rdwen  = rdwen_q[ret_ptr_q];
    assign bus.ret_rdidx  = rdidx_q[ret_ptr_q];
    assign bus.ret_pc     = pc_q[ret_ptr_q];
    assign bus.oitf_empty = oitf_empty;
    assign bus.oitf_full  = oitf_full;

endmodule

// File: doc/lieat_exu_oitf.md
# lieat_exu_oitf

Outstanding Instruction Track FIFO for the EXU. It records every long-latency instruction (LSU or MUL/DIV) at dispatch and releases it in order when the write-back unit accepts that instruction's result. Dispatch uses its combinational RAW/WAW match outputs to stall hazards, and the write-back unit uses `oitf_waw_dep`. It sits between the dispatch stage (allocate side) and the write-back arbiter (retire side).

## Interface
- `OITF_DEPTH`, 4: number of entries; power of two, ≥2.
- `PTR_W`, 2: log2(`OITF_DEPTH`).
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: reset is asynchronous and active-low; all state clears while low.
- `dis_ena` input 1: allocate request from dispatch.
- `dis_ready` output 1: entry available (not full).
- `dis_rdwen` input 1: the allocated instruction writes rd.
- `dis_rdidx` input `REG_IDX`: destination register of the allocated instruction.
- `dis_pc` input `XLEN`: PC of the allocated instruction.
- `dis_ptr` output `PTR_W`: index that the next allocation will use.
- `ret_ena` input 1: retire the oldest entry (WBU accepted an LSU/MULDIV write-back).
- `ret_ptr` output `PTR_W`: index of the oldest entry.
- `ret_rdwen` output 1: rdwen field of the oldest entry.
- `ret_rdidx` output `REG_IDX`: rd field of the oldest entry.
- `ret_pc` output `XLEN`: pc field of the oldest entry.
- `disp_rs1en`, `disp_rs2en`, `disp_rdwen` input 1 each: operand and destination enables of the instruction in dispatch.
- `disp_rs1idx`, `disp_rs2idx`, `disp_rdidx` input `REG_IDX` each: operand and destination indices of the instruction in dispatch.
- `oitfrd_match_disprs1`, `oitfrd_match_disprs2` output 1 each: RAW hazard flags.
- `oitfrd_match_disprd` output 1: WAW hazard flag.
- `oitf_waw_dep` output 1: the oldest valid entry's rd matches `disp_rdidx` with both write enables set.
- `oitf_empty` output 1: no valid entry.
- `oitf_full` output 1: all entries valid.

## Operation
- **Storage.** Each entry holds `vld`, `rdwen`, `rdidx` and `pc`.
- **Pointers.** `alc_ptr` and `ret_ptr` are each `PTR_W` bits plus a wrap flag.
  - A pointer increments modulo `OITF_DEPTH`.
  - Its flag toggles when the pointer wraps from `OITF_DEPTH-1` to 0.
- **Full/empty decode.**
  - `oitf_empty`: pointers are equal and flags are equal.
  - `oitf_full`: pointers are equal and flags differ.
  - `dis_ready = ~oitf_full`.
- **Allocate (`alc_fire = dis_ena & dis_ready`).**
  - Write `vld=1`, `rdwen`, `rdidx` and `pc` at `alc_ptr`, then advance `alc_ptr`.
  - `dis_ena` while full is ignored: no state change.
- **Retire (`ret_fire = ret_ena & ~oitf_empty`).**
  - Clear `vld` at `ret_ptr`, then advance `ret_ptr`.
  - `ret_ena` while empty is ignored.
  - Retire order is strictly FIFO. The WBU guarantees results of tracked instructions arrive in allocation order.
- **Simultaneous allocate and retire.**
  - Both fire in the same cycle when the FIFO is neither full nor empty. Occupancy is unchanged.
  - When empty, only the allocate fires.
  - When full, only the retire fires. `dis_ready` is 0 that cycle, so there is no same-cycle bypass.
- **Match logic** (combinational over all entries).
  - An entry matches when `vld & rdwen & (rdidx == idx) & (idx != 0)`.
  - `oitfrd_match_disprs1` = OR over entries, gated by `disp_rs1en`. `oitfrd_match_disprs2` follows the same rule with `disp_rs2en`.
  - `oitfrd_match_disprd` follows the same rule, gated by `disp_rdwen`.
- **`oitf_waw_dep`.** Evaluates the same match against the entry at `ret_ptr` only, gated by `disp_rdwen` and `~oitf_empty`.
- **`ret_*` outputs.** Combinational reads of the entry at `ret_ptr`. They are don't-care when empty, but must be driven (no X from uninitialised storage, because entries reset to 0).

## Timing
- **Reset (asynchronous, while `reset`=0).**
  - All `vld`, fields, pointers and flags go to 0.
  - Resulting outputs: `oitf_empty`=1, `oitf_full`=0, `dis_ready`=1, `dis_ptr`=0, `ret_ptr`=0, `ret_*`=0, all match outputs 0.
  - Reset asserted mid-operation discards every outstanding entry immediately, without waiting for a clock edge.
- **Allocation.** Visible on the match outputs, `oitf_empty` and `dis_ptr` starting the cycle after the `alc_fire` edge.
- **Retire.** Removes the entry from the match outputs the cycle after the `ret_fire` edge. A same-cycle dispatch query still sees the retiring entry (conservative stall).
- **Latency.** All outputs are combinational from registered state plus the `disp_*` inputs. There is no input-to-state bypass.
- **Throughput.** One allocate and one retire per cycle.

## Test plan
- **Reset.** Release reset, then idle → `oitf_empty`=1, `dis_ready`=1, `dis_ptr`=0, `ret_ptr`=0, all matches 0.
- **Fill.** Allocate rd=1,2,3,4 (`rdwen`=1) on consecutive cycles → after the 4th, `oitf_full`=1 and `dis_ready`=0. A 5th `dis_ena` with rd=5 changes nothing; `ret_rdidx` stays 1.
- **Hazards.** With entries rd={0,3}, query rs1=3, rs2=0, rd=3 → `match_rs1`=1, `match_rs2`=0, `match_rd`=1. `oitf_waw_dep`=0 because the oldest entry is rd=0.
- **Wrap.** Do 4 allocates, 4 retires, then 2 allocates → `ret_rdidx` sequence 1,2,3,4. Pointers then read `dis_ptr`=2, `ret_ptr`=0 with both flags toggled, and `oitf_empty`=0.
- **Simultaneous.** With 2 entries, assert `dis_ena` and `ret_ena` together for 3 cycles → occupancy stays 2 and `ret_pc` advances each cycle. With the FIFO empty, `dis_ena`+`ret_ena` → 1 entry, and `ret_pc` equals the allocated pc.
- **Reset mid-operation.** With 3 entries, drive `reset`=0 between clock edges → `oitf_empty`=1 and all matches 0 before the next edge. After release, the first allocate lands at index 0.
